// File: rtl/polar12_pkg.sv
// Shared widths, constants and state encoding for the polar12 CORDIC converter.
package polar12_pkg;
   localparam int unsigned W_IN   = 12;
   localparam int unsigned W_INT  = 16;
   localparam int unsigned W_EXT  = W_INT + 1;
   localparam int unsigned W_PROD = 2 * W_IN;
   localparam int unsigned W_CNT  = 4;
   localparam int unsigned ITER   = 12;
   localparam int unsigned K      = 2487;

   // atan(2^-i) with full circle = 65536
   localparam logic signed [W_INT-1:0] ATAN [ITER] = '{
      16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297, 16'sd651, 16'sd326,
      16'sd163,  16'sd81,   16'sd41,   16'sd20,   16'sd10,  16'sd5
   };

   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t ROT  = 2'd1;
   localparam state_t DONE = 2'd2;

   // Round Q.2 to integer and clamp symmetrically to +/-2047
   function automatic logic signed [W_IN-1:0] rnd_sat(input logic signed [W_INT-1:0] v);
      logic signed [W_EXT-1:0] r;
      r = W_EXT'(v) + 17'sd2;
      r = r >>> 2;
      if (r > 17'sd2047)       return 12'sd2047;
      else if (r < -17'sd2047) return -12'sd2047;
      else                     return W_IN'(r);
   endfunction
endpackage

// File: rtl/polar12_if.sv
// Sample/result bus between the phase/envelope source and polar12.
interface polar12_if;
   import polar12_pkg::*;
   logic [W_IN-1:0]        m;
   logic [W_IN-1:0]        p;
   logic                   iv;
   logic                   rdy;
   logic signed [W_IN-1:0] x;
   logic signed [W_IN-1:0] y;
   logic                   ov;

   modport master (output m, p, iv, input rdy, x, y, ov);
   modport slave  (input m, p, iv, output rdy, x, y, ov);
endinterface

// File: rtl/polar12_cordic_step.sv
// One CORDIC micro-rotation in rotation mode (combinational).
module cordic_step
   import polar12_pkg::*;
(
   input  logic signed [W_INT-1:0] xr,
   input  logic signed [W_INT-1:0] yr,
   input  logic signed [W_INT-1:0] zr,
   input  logic [W_CNT-1:0]        i,
   input  logic signed [W_INT-1:0] atan_i,
   output logic signed [W_INT-1:0] xn_c,
   output logic signed [W_INT-1:0] yn_c,
   output logic signed [W_INT-1:0] zn_c
);
   logic signed [W_INT-1:0] xs;
   logic signed [W_INT-1:0] ys;

   always_comb begin
      xs = xr >>> i;
      ys = yr >>> i;
      if (!zr[W_INT-1]) begin
         xn_c = xr - ys;
         yn_c = yr + xs;
         zn_c = zr - atan_i;
      end else begin
         xn_c = xr + ys;
         yn_c = yr - xs;
         zn_c = zr + atan_i;
      end
   end
endmodule

// File: rtl/polar12.sv
// Iterative polar-to-rectangular converter: quadrant fold, 12 CORDIC steps, round and saturate.
module polar12
   import polar12_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   polar12_if.slave  io
);
   state_t                  state, state_n;
   logic [W_CNT-1:0]        cnt, cnt_n;
   logic signed [W_INT-1:0] xr, yr, zr, xr_n, yr_n, zr_n;
   logic signed [W_INT-1:0] xs_c, ys_c, zs_c, atan_c, mk_c, z0_c;
   logic [W_PROD-1:0]       prod_c;
   logic signed [W_IN-1:0]  x_r, y_r, x_n, y_n;
   logic                    ov_r, ov_n, rdy_r, rdy_n;

   assign io.x   = x_r;
   assign io.y   = y_r;
   assign io.ov  = ov_r;
   assign io.rdy = rdy_r;

   // Gain-prescaled magnitude in Q.2 and first-quadrant residual angle
   assign prod_c = W_PROD'(io.m) * W_PROD'(K);
   assign mk_c   = $signed(W_INT'(prod_c >> 10));
   assign z0_c   = $signed({2'b00, io.p[9:0], 4'b0000});
   assign atan_c = (cnt < W_CNT'(ITER)) ? ATAN[cnt] : '0;

   cordic_step u_step (
      .xr(xr), .yr(yr), .zr(zr), .i(cnt), .atan_i(atan_c),
      .xn_c(xs_c), .yn_c(ys_c), .zn_c(zs_c)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      xr_n    = xr;
      yr_n    = yr;
      zr_n    = zr;
      x_n     = x_r;
      y_n     = y_r;
      ov_n    = 1'b0;
      rdy_n   = rdy_r;
      case (state)
         IDLE: begin
            if (io.iv) begin
               state_n = ROT;
               rdy_n   = 1'b0;
               cnt_n   = '0;
               zr_n    = z0_c;
               case (io.p[11:10])
                  2'b00:   begin xr_n = mk_c;  yr_n = '0;    end
                  2'b01:   begin xr_n = '0;    yr_n = mk_c;  end
                  2'b10:   begin xr_n = -mk_c; yr_n = '0;    end
                  default: begin xr_n = '0;    yr_n = -mk_c; end
               endcase
            end
         end
         ROT: begin
            xr_n  = xs_c;
            yr_n  = ys_c;
            zr_n  = zs_c;
            cnt_n = cnt + W_CNT'(1);
            if (cnt == W_CNT'(ITER - 1)) state_n = DONE;
         end
         DONE: begin
            x_n     = rnd_sat(xr);
            y_n     = rnd_sat(yr);
            ov_n    = 1'b1;
            rdy_n   = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            rdy_n   = 1'b1;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         xr    <= '0;
         yr    <= '0;
         zr    <= '0;
         x_r   <= '0;
         y_r   <= '0;
         ov_r  <= 1'b0;
         rdy_r <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         xr    <= xr_n;
         yr    <= yr_n;
         zr    <= zr_n;
         x_r   <= x_n;
         y_r   <= y_n;
         ov_r  <= ov_n;
         rdy_r <= rdy_n;
      end
   end
endmodule
